// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage -- MEM stage of the RV32 core.
//
// Consumes the execute->memory latch. Non-memory instructions, misaligned
// accesses and illegal instructions produce their result at the next edge.
// Aligned loads/stores capture the latch, move to BUSY and hold a data-bus
// request until dmem_ready, or until the timeout counter expires. Branches
// and jumps are resolved against the fetch prediction and registered
// together with the result.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   in_valid                  latch holds a live instruction
//   in_pc .. in_branch_target execute-stage values (WORD_W bits)
//   in_rd                     destination register
//   in_dread / in_dwrite      load / store size (0 none, 1 B, 2 H, 3 W)
//   in_reg_wr_src             writeback source: 0 alu, 1 load, 2 pc+4
//   in_reg_wr_mem(_signed)    load size (0 B, 1 H, 2 W) and sign extension
//   in_branch_pol/_predict    branch polarity, fetch prediction
//   in_illegal_inst           decode flagged the instruction illegal
//   in_pc_ctrl                0 inc, 1 branch, 2 JAL, 3 JALR, 4 exc return
//   dmem_*                    data bus request / response
//   stall                     upstream must hold the latch
//   redirect, redirect_pc     one-cycle fetch redirect
//   wb_valid, wb_rd, wb_data  one-cycle writeback result
//   exc_valid, exc_cause      one-cycle exception (0 illegal, 1 misaligned,
//                             2 bus timeout)
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_alu_out,
    input  logic [WORD_W-1:0] in_rdat2,
    input  logic [WORD_W-1:0] in_pc_plus_imm,
    input  logic [WORD_W-1:0] in_branch_target,
    input  logic [4:0]        in_rd,
    input  logic              in_dread,
    input  logic [1:0]        in_dwrite,
    input  logic [1:0]        in_reg_wr_src,
    input  logic [1:0]        in_reg_wr_mem,
    input  logic              in_reg_wr_mem_signed,
    input  logic              in_branch_pol,
    input  logic              in_branch_predict,
    input  logic              in_illegal_inst,
    input  logic [2:0]        in_pc_ctrl,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              redirect,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [WORD_W-1:0] wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_cause
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JAL    = 3'd2;
    localparam logic [2:0] PC_JALR   = 3'd3;
    localparam logic [2:0] PC_ERET   = 3'd4;

    localparam logic [1:0] EXC_ILLEGAL  = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_PC4  = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    // Byte-lane enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd1:    return 4'b0001 << lane;
            2'd2:    return 4'b0011 << lane;
            2'd3:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Store data replicated so every lane the strobe may select carries it.
    function automatic logic [WORD_W-1:0] store_data(input logic [1:0] size, input logic [WORD_W-1:0] d);
        case (size)
            2'd1:    return {(WORD_W/8){d[7:0]}};
            2'd2:    return {(WORD_W/16){d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Select the addressed lane of a read word and extend it to full width.
    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] rdata,
                                                      input logic [1:0] lane,
                                                      input logic [1:0] size,
                                                      input logic sgn);
        logic [WORD_W-1:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'd0:    return {{(WORD_W-8){sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{(WORD_W-16){sgn & sh[15]}}, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    state_t            state, state_nxt;
    logic [7:0]        tmo_cnt;

    logic              mem_op_p0;
    logic              misalign_p0;
    logic              start_p0;
    logic              issue_p0;
    logic              taken_p0;
    logic [WORD_W-1:0] target_p0;
    logic [WORD_W-1:0] pc_plus4_p0;
    logic              redirect_p0;
    logic [WORD_W-1:0] redirect_pc_p0;
    logic [WORD_W-1:0] alu_result_p0;

    // Instruction fields captured on entry to BUSY; the latch may change
    // underneath us while the bus transaction is outstanding.
    logic [1:0]        lane_p1;
    logic [4:0]        rd_p1;
    logic [1:0]        src_p1;
    logic [1:0]        ld_size_p1;
    logic              ld_signed_p1;
    logic [WORD_W-1:0] alu_p1;
    logic [WORD_W-1:0] pc_plus4_p1;
    logic [WORD_W-1:0] mem_result_p1;

    logic              bus_done;
    logic              bus_timeout;

    // ---- stage p0: decode of the latched instruction ----
    always_comb begin
        mem_op_p0 = in_dread | (in_dwrite != 2'd0);
        if (in_dread)
            misalign_p0 = (in_reg_wr_mem == 2'd1 && in_alu_out[0]) ||
                          (in_reg_wr_mem >= 2'd2 && in_alu_out[1:0] != 2'b00);
        else
            misalign_p0 = (in_dwrite == 2'd2 && in_alu_out[0]) ||
                          (in_dwrite == 2'd3 && in_alu_out[1:0] != 2'b00);
        misalign_p0 = misalign_p0 & mem_op_p0;
        start_p0 = (state == IDLE) && in_valid && mem_op_p0 && !in_illegal_inst && !misalign_p0;
        issue_p0 = (state == IDLE) && in_valid && !start_p0;
    end

    always_comb begin
        taken_p0    = 1'b0;
        target_p0   = in_pc_plus_imm;
        pc_plus4_p0 = in_pc + WORD_W'(4);
        case (in_pc_ctrl)
            PC_BRANCH: taken_p0 = (in_alu_out == '0) ^ in_branch_pol;
            PC_JAL:    taken_p0 = 1'b1;
            PC_JALR: begin
                taken_p0  = 1'b1;
                target_p0 = {in_alu_out[WORD_W-1:1], 1'b0};
            end
            default: ;
        endcase
        if (in_pc_ctrl == PC_ERET) begin
            redirect_p0    = 1'b1;
            redirect_pc_p0 = in_alu_out;
        end else begin
            // A correct direction prediction can still carry a stale target.
            redirect_p0    = (taken_p0 != in_branch_predict) ||
                             (taken_p0 && in_branch_target != target_p0);
            redirect_pc_p0 = taken_p0 ? target_p0 : pc_plus4_p0;
        end
        case (in_reg_wr_src)
            SRC_PC4: alu_result_p0 = pc_plus4_p0;
            default: alu_result_p0 = in_alu_out;
        endcase
    end

    // ---- stage p1: bus transaction state ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (state == BUSY) ? tmo_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        bus_done    = (state == BUSY) && dmem_ready;
        bus_timeout = (state == BUSY) && !dmem_ready && (tmo_cnt == TMO_LAST);
        state_nxt   = state;
        case (state)
            IDLE:    if (start_p0) state_nxt = BUSY;
            BUSY:    if (bus_done || bus_timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = (state == BUSY);

    always_ff @(posedge CLK) begin
        if (start_p0) begin
            lane_p1      <= in_alu_out[1:0];
            rd_p1        <= in_rd;
            src_p1       <= in_reg_wr_src;
            ld_size_p1   <= in_reg_wr_mem;
            ld_signed_p1 <= in_reg_wr_mem_signed;
            alu_p1       <= in_alu_out;
            pc_plus4_p1  <= pc_plus4_p0;
        end
    end

    always_comb begin
        case (src_p1)
            SRC_MEM: mem_result_p1 = load_extend(dmem_rdata, lane_p1, ld_size_p1, ld_signed_p1);
            SRC_PC4: mem_result_p1 = pc_plus4_p1;
            default: mem_result_p1 = alu_p1;
        endcase
    end

    // ---- stage p2: registered outputs to bus, fetch and writeback ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dmem_ren    <= 1'b0;
            dmem_wen    <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_wstrb  <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            exc_valid   <= 1'b0;
            exc_cause   <= '0;
        end else begin
            wb_valid  <= 1'b0;
            redirect  <= 1'b0;
            exc_valid <= 1'b0;

            if (issue_p0) begin
                wb_valid <= 1'b1;
                if (in_illegal_inst) begin
                    exc_valid <= 1'b1;
                    exc_cause <= EXC_ILLEGAL;
                    wb_rd     <= '0;
                    wb_data   <= '0;
                end else if (misalign_p0) begin
                    exc_valid <= 1'b1;
                    exc_cause <= EXC_MISALIGN;
                    wb_rd     <= '0;
                    wb_data   <= '0;
                end else begin
                    wb_rd       <= in_rd;
                    wb_data     <= alu_result_p0;
                    redirect    <= redirect_p0;
                    redirect_pc <= redirect_pc_p0;
                end
            end

            if (start_p0) begin
                dmem_ren   <= in_dread;
                dmem_wen   <= !in_dread;
                dmem_addr  <= {in_alu_out[WORD_W-1:2], 2'b00};
                dmem_wdata <= store_data(in_dwrite, in_rdat2);
                dmem_wstrb <= in_dread ? 4'b0000 : store_strobe(in_dwrite, in_alu_out[1:0]);
            end

            if (bus_done) begin
                dmem_ren   <= 1'b0;
                dmem_wen   <= 1'b0;
                dmem_wstrb <= '0;
                wb_valid   <= 1'b1;
                wb_rd      <= rd_p1;
                wb_data    <= mem_result_p1;
            end

            if (bus_timeout) begin
                dmem_ren   <= 1'b0;
                dmem_wen   <= 1'b0;
                dmem_wstrb <= '0;
                wb_valid   <= 1'b1;
                wb_rd      <= '0;
                wb_data    <= '0;
                exc_valid  <= 1'b1;
                exc_cause  <= EXC_TIMEOUT;
            end
        end
    end

endmodule
